i2s_frame_pair: RTL
===================

# i2s_frame_pair

Stereo frame assembler directly downstream of the I2S receiver. It takes the receiver's per-word strobe, data word and channel flag, and pairs each left word with the right word that follows it into one stereo frame. Completed frames are buffered in a small FIFO and handed to the mixer core over a valid/ready interface. Orphaned words and FIFO overflows are counted for debug.

## Interface
- BITS_PRECISION, 24: sample width; must match the receiver.
- FIFO_DEPTH, 4: frame FIFO entries; power of two, at least 2.
- LEFT_LEVEL, 0: value of `in_left_rightn` on the `in_en` cycle that marks the completed word as left.
- CNT_W, 8: width of each error counter.

Ports:
- `sck` input 1: bit clock, the only clock; all logic runs on posedge (the receiver updates on negedge).
- `rst` input 1: synchronous, active-high reset.
- `in_data` input BITS_PRECISION: completed word from the receiver.
- `in_left_rightn` input 1: receiver channel flag.
- `in_en` input 1: one-cycle strobe; `in_data` is valid.
- `out_left` output BITS_PRECISION: left sample of the head frame.
- `out_right` output BITS_PRECISION: right sample of the head frame.
- `out_valid` output 1: FIFO is non-empty.
- `out_ready` input 1: consumer accepts the head frame when `out_valid` and `out_ready` are both high.
- `level` output clog2(FIFO_DEPTH)+1: number of frames stored.
- `orphan_cnt` output CNT_W: number of unpaired words dropped; saturating.
- `ovf_cnt` output CNT_W: number of completed frames dropped because the FIFO was full; saturating.
- `clr_cnt` input 1: synchronous clear of both counters.

## Operation
- A word is "left" when `in_en` is high and `in_left_rightn` equals LEFT_LEVEL. Otherwise it is "right".
- The pairing FSM has two states, WAIT_L (the reset state) and WAIT_R. A `hold_l` register stores the pending left word.
  - WAIT_L, left word: `hold_l` takes `in_data`; go to WAIT_R.
  - WAIT_L, right word: drop the word; increment `orphan_cnt`; stay in WAIT_L.
  - WAIT_R, right word: push {`hold_l`, `in_data`}; go to WAIT_L.
  - WAIT_R, left word: the previous left word is orphaned. Increment `orphan_cnt`, `hold_l` takes `in_data`, stay in WAIT_R.
  - No `in_en`: hold state.
- The FIFO is register-based, with wrap-around read and write pointers of clog2(FIFO_DEPTH) bits and a separate occupancy count.
  - `out_left` and `out_right` are the head entry read combinationally from the FIFO registers.
  - When `out_valid` is low, the data outputs are don't-care.
- Push while full:
  - If a pop occurs in the same cycle, the push is accepted and `level` stays at FIFO_DEPTH.
  - Otherwise the frame is dropped, `ovf_cnt` increments, and the FIFO contents are untouched.
- Push and pop in the same cycle while not full: `level` is unchanged and both pointers advance.
- Pop while empty: impossible by definition (`out_valid` is low). Nothing changes.
- Counters saturate at 2^CNT_W-1.
  - `clr_cnt` has priority over an increment in the same cycle; the result is 0.
  - `orphan_cnt` and `ovf_cnt` can both update in the same cycle only from different events, so each is independent.
- Reset, including reset in the middle of a frame:
  - Returns to WAIT_L, zeroes `hold_l`, both pointers, `level` and both counters, and drives `out_valid` to 0.
  - A pending left word is discarded and not counted.
  - `in_en` in the reset cycle is ignored.

## Timing
- All state updates on posedge `sck`. Inputs are sampled on the posedge following the receiver's negedge update.
- Latency: a right-word `in_en` sampled at edge N raises `out_valid` (if the FIFO was empty) and presents the frame on `out_left`/`out_right` immediately after edge N.
- A handshake sampled at edge M removes the head frame. The next frame, or `out_valid`=0, appears immediately after edge M.
- `out_valid` does not depend combinationally on `out_ready`.
- Throughput: one push and one pop per cycle maximum. In practice frames arrive at most once per 2×BITS_PRECISION cycles.
- All outputs are 0 after reset.

## Test plan
- Basic pair: L=0x123456, then R=0xABCDEF, `out_ready`=1 → one frame {0x123456, 0xABCDEF}; `out_valid` high exactly one cycle; `orphan_cnt`=0.
- Orphans: R, L=0x000001, L=0x000002, R=0x000003 → single frame {0x000002, 0x000003}; `orphan_cnt`=2.
- Overflow: `out_ready`=0, push 5 frames with FIFO_DEPTH=4 → `level`=4, `ovf_cnt`=1. Then drain: exactly frames 1-4 appear in order.
- Full plus simultaneous pop: FIFO full, `out_ready`=1 on the cycle of the 5th push → `ovf_cnt`=0, `level` stays 4, order preserved.
- Pointer wrap: 20 frames at random `out_ready` back-pressure, never overflowing → output sequence equals input sequence.
- Reset mid-frame and counters: assert `rst` in WAIT_R with 2 frames stored → `level`=0, `out_valid`=0, counters 0. A following R word counts as an orphan. Drive 300 orphans with CNT_W=8 → `orphan_cnt`=255; `clr_cnt` → 0.

Source files
------------

// File: rtl/i2s_frame_pair.sv
// i2s_frame_pair: pairs I2S left/right words into stereo frames, buffers them in a FIFO
//
// Ports:
//   sck            - bit clock; all state updates on posedge
//   rst            - synchronous active-high reset
//   in_data        - completed word from the I2S receiver
//   in_left_rightn - receiver channel flag (equals LEFT_LEVEL for a left word)
//   in_en          - one-cycle strobe qualifying in_data
//   out_left       - left sample of the head frame
//   out_right      - right sample of the head frame
//   out_valid      - FIFO holds at least one frame
//   out_ready      - consumer accepts the head frame when out_valid is high
//   level          - number of frames stored
//   orphan_cnt     - saturating count of unpaired words dropped
//   ovf_cnt        - saturating count of frames dropped on a full FIFO
//   clr_cnt        - synchronous clear of both counters
module i2s_frame_pair #(
    parameter int   BITS_PRECISION = 24,
    parameter int   FIFO_DEPTH     = 4,
    parameter logic LEFT_LEVEL     = 1'b0,
    parameter int   CNT_W          = 8
) (
    input  logic                          sck,
    input  logic                          rst,
    input  logic [BITS_PRECISION-1:0]     in_data,
    input  logic                          in_left_rightn,
    input  logic                          in_en,
    output logic [BITS_PRECISION-1:0]     out_left,
    output logic [BITS_PRECISION-1:0]     out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [CNT_W-1:0]              orphan_cnt,
    output logic [CNT_W-1:0]              ovf_cnt,
    input  logic                          clr_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {WAIT_L, WAIT_R} state_t;

    state_t                    state_q;
    logic [BITS_PRECISION-1:0] hold_l_q;
    logic [BITS_PRECISION-1:0] mem_l_q [FIFO_DEPTH];
    logic [BITS_PRECISION-1:0] mem_r_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [AW:0]               level_q, level_d;
    logic [CNT_W-1:0]          orphan_q, orphan_d, ovf_q, ovf_d;
    logic                      is_left, is_right, push, pop, full, wr_en, ovf, orphan;

    assign is_left  = in_en && (in_left_rightn == LEFT_LEVEL);
    assign is_right = in_en && (in_left_rightn != LEFT_LEVEL);
    assign push     = (state_q == WAIT_R) && is_right;
    assign pop      = out_valid && out_ready;
    assign full     = level_q == (AW+1)'(FIFO_DEPTH);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en    = push && (!full || pop);
    assign ovf      = push && full && !pop;
    assign orphan   = (state_q == WAIT_L) ? is_right : is_left;

    always_comb begin
        level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        orphan_d = clr_cnt ? '0 : (orphan && orphan_q != '1) ? orphan_q + CNT_W'(1) : orphan_q;
        ovf_d    = clr_cnt ? '0 : (ovf && ovf_q != '1) ? ovf_q + CNT_W'(1) : ovf_q;
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state_q  <= WAIT_L;
            hold_l_q <= '0;
        end else if (is_left) begin
            state_q  <= WAIT_R;
            hold_l_q <= in_data;
        end else if (is_right) begin
            state_q  <= WAIT_L;
        end
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_l_q[i] <= '0;
                mem_r_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            orphan_q <= '0;
            ovf_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_l_q[wr_ptr_q] <= hold_l_q;
                mem_r_q[wr_ptr_q] <= in_data;
                wr_ptr_q          <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q  <= level_d;
            orphan_q <= orphan_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_left   = mem_l_q[rd_ptr_q];
    assign out_right  = mem_r_q[rd_ptr_q];
    assign out_valid  = level_q != '0;
    assign level      = level_q;
    assign orphan_cnt = orphan_q;
    assign ovf_cnt    = ovf_q;
endmodule
